// File: rtl/odo_sbox_serializer_if.sv
// Handshake bundle for odo_sbox_serializer: word input, sbox lookup port and word output.
// The slave modport is the serializer side; master is the environment side.
interface odo_sbox_serializer_if #(
  parameter int NCHUNK = 10
) ();
  localparam int W = 6 * NCHUNK;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [5:0]   sbox_in;
  logic [5:0]   sbox_out;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  modport slave (
    input  in_valid,
    input  in_data,
    input  sbox_out,
    input  out_ready,
    output in_ready,
    output sbox_in,
    output out_valid,
    output out_data,
    output busy
  );

  modport master (
    output in_valid,
    output in_data,
    output sbox_out,
    output out_ready,
    input  in_ready,
    input  sbox_in,
    input  out_valid,
    input  out_data,
    input  busy
  );
endinterface

// File: rtl/odo_sbox_serializer.sv
// Pushes a word through an external registered 6-bit sbox one chunk per cycle and
// reassembles the substituted chunks into a word offered on a valid/ready output.
module odo_sbox_serializer #(
  parameter int NCHUNK = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  odo_sbox_serializer_if.slave bus
);
  localparam int W  = 6 * NCHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_word;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic          r_in_ready;
  logic          r_busy;

  logic [IW-1:0] w_prev_idx;
  logic [BW-1:0] w_cur_base;
  logic [BW-1:0] w_prev_base;
  logic [5:0]    w_sbox_in;
  logic          w_in_hs;
  logic          w_out_hs;

  assign w_prev_idx  = r_idx - IW'(1);
  assign w_cur_base  = BW'(r_idx) * BW'(6);
  assign w_prev_base = BW'(w_prev_idx) * BW'(6);
  assign w_in_hs     = bus.in_valid & r_in_ready;
  assign w_out_hs    = r_out_valid & bus.out_ready;

  // Chunk select toward the sbox; forced to zero whenever reset is asserted.
  always_comb begin
    w_sbox_in = 6'h00;
    if ((r_state == FEED) && !rst) begin
      w_sbox_in = r_word[w_cur_base +: 6];
    end else begin
      w_sbox_in = 6'h00;
    end
  end

  // Control FSM; the sbox result for chunk k arrives one edge after chunk k was driven,
  // so FEED captures field idx-1 and DRAIN captures the last field.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_word      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_hs) begin
            r_word     <= bus.in_data;
            r_idx      <= '0;
            r_state    <= FEED;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        FEED: begin
          if (r_idx != '0) begin
            r_out_data[w_prev_base +: 6] <= bus.sbox_out;
          end
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= DRAIN;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DRAIN: begin
          r_out_data[W-1 -: 6] <= bus.sbox_out;
          r_out_valid          <= 1'b1;
          r_state              <= DONE;
        end
        DONE: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_idx       <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sbox_in   = w_sbox_in;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_odo_sbox_serializer.sv
// Directed bench for odo_sbox_serializer with a registered sbox stand-in and
// hand-computed expected words.
module tb_odo_sbox_serializer;
  localparam int NCHUNK = 10;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   edges;

  odo_sbox_serializer_if #(.NCHUNK(NCHUNK)) sif ();

  odo_sbox_serializer #(.NCHUNK(NCHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External sbox: fixed table for the chunks the bench uses, anything else is filler.
  function automatic logic [5:0] sbox_f(input logic [5:0] v);
    case (v)
      6'h00:   sbox_f = 6'h21;
      6'h01:   sbox_f = 6'h00;
      6'h02:   sbox_f = 6'h0e;
      6'h03:   sbox_f = 6'h2d;
      6'h04:   sbox_f = 6'h33;
      6'h05:   sbox_f = 6'h20;
      6'h06:   sbox_f = 6'h25;
      6'h07:   sbox_f = 6'h2c;
      6'h08:   sbox_f = 6'h1e;
      6'h09:   sbox_f = 6'h1c;
      6'h3f:   sbox_f = 6'h28;
      default: sbox_f = v ^ 6'h15;
    endcase
  endfunction

  always @(posedge clk) sif.sbox_out <= sbox_f(sif.sbox_in);

  function automatic logic [59:0] rep(input logic [5:0] v);
    rep = {10{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [59:0] word);
    sif.in_data  = word;
    sif.in_valid = 1'b1;
    tick();
    sif.in_valid = 1'b0;
    sif.in_data  = 60'hABC_DEF0_1234_5678;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while ((sif.out_valid !== 1'b1) && (n < 30)) begin
      tick();
      n++;
    end
  endtask

  logic [59:0] in_seq;
  logic [59:0] out_seq;
  logic [59:0] mix_in;
  logic [59:0] mix_out;
  logic [59:0] wv [4];
  logic [59:0] ev [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    in_seq  = {6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
    out_seq = {6'h1c, 6'h1e, 6'h2c, 6'h25, 6'h20, 6'h33, 6'h2d, 6'h0e, 6'h00, 6'h21};
    mix_in  = {6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    mix_out = {6'h28, 6'h28, 6'h28, 6'h28, 6'h28, 6'h21, 6'h21, 6'h21, 6'h21, 6'h21};
    wv[0] = in_seq;      ev[0] = out_seq;
    wv[1] = rep(6'h3f);  ev[1] = rep(6'h28);
    wv[2] = rep(6'h00);  ev[2] = rep(6'h21);
    wv[3] = mix_in;      ev[3] = mix_out;

    // Reset state, with reset held for two edges
    rst           = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", sif.in_ready, 1);
    chk("rst_out_valid", sif.out_valid, 0);
    chk("rst_out_data", sif.out_data, 0);
    chk("rst_busy", sif.busy, 0);
    chk("rst_sbox_in", sif.sbox_in, 0);
    rst = 1'b0;
    tick();

    // Zero word, out_ready high: 11-edge latency, all fields 0x21, single-cycle pulse
    sif.out_ready = 1'b1;
    send('0);
    chk("A_busy", sif.busy, 1);
    chk("A_in_ready", sif.in_ready, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("A_ov_low", sif.out_valid, 0);
    end
    tick();
    chk("A_ov_high", sif.out_valid, 1);
    chk("A_data", sif.out_data, rep(6'h21));
    tick();
    chk("A_ov_pulse", sif.out_valid, 0);
    chk("A_in_ready_back", sif.in_ready, 1);
    chk("A_data_hold", sif.out_data, rep(6'h21));

    // Chunk i = i: sbox_in walks 0..9, fields map through the table
    send(in_seq);
    for (int i = 0; i < 10; i++) begin
      chk("B_sbox_in", sif.sbox_in, 64'(i));
      tick();
    end
    chk("B_sbox_in_drain", sif.sbox_in, 0);
    chk("B_ov_drain", sif.out_valid, 0);
    tick();
    chk("B_ov_high", sif.out_valid, 1);
    chk("B_data", sif.out_data, out_seq);
    tick();
    chk("B_ov_pulse", sif.out_valid, 0);

    // All 0x3f with back-pressure: output stalls and holds for 5 cycles
    sif.out_ready = 1'b0;
    send(rep(6'h3f));
    wait_valid(edges);
    chk("C_latency", edges, 11);
    chk("C_data", sif.out_data, rep(6'h28));
    sif.in_valid = 1'b1;
    sif.in_data  = rep(6'h05);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("C_ov_hold", sif.out_valid, 1);
      chk("C_data_hold", sif.out_data, rep(6'h28));
      chk("C_in_ready", sif.in_ready, 0);
    end
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b1;
    tick();
    chk("C_release_ov", sif.out_valid, 0);
    chk("C_release_ir", sif.in_ready, 1);

    // Reset in the middle of FEED at idx 4, then a fresh word
    send(in_seq);
    for (int i = 0; i < 4; i++) tick();
    chk("D_sbox_idx4", sif.sbox_in, 4);
    rst = 1'b1;
    #1;
    chk("D_sbox_in_rst", sif.sbox_in, 0);
    tick();
    chk("D_in_ready", sif.in_ready, 1);
    chk("D_out_valid", sif.out_valid, 0);
    chk("D_out_data", sif.out_data, 0);
    chk("D_busy", sif.busy, 0);
    rst = 1'b0;
    send(mix_in);
    wait_valid(edges);
    chk("D_latency", edges, 11);
    chk("D_data", sif.out_data, mix_out);
    tick();
    chk("D_ov_pulse", sif.out_valid, 0);

    // in_valid held high with in_data changing every cycle: 13-edge word period
    sif.in_valid  = 1'b1;
    sif.out_ready = 1'b1;
    for (int n = 0; n < 39; n++) begin
      sif.in_data = wv[n % 4];
      tick();
      chk("E_out_valid", sif.out_valid, 64'((n % 13) == 11));
      chk("E_in_ready", sif.in_ready, 64'((n % 13) == 12));
      if ((n % 13) == 11) chk("E_data", sif.out_data, ev[n / 13]);
    end
    sif.in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/odo_sbox_serializer.md
ODO_SBOX_SERIALIZER -- requirements
Module: odo_sbox_serializer

Interface
REQ-001 SHALL have parameter: NCHUNK, default 10, number of 6-bit chunks per word (W = 6*NCHUNK).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports: clk  input  1  clock, all state updates on posedge.
REQ-004 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port: in_valid  input  1  upstream word valid.
REQ-006 SHALL have port: in_ready  output  1  block can accept a word.
REQ-007 SHALL have port: in_data  input  W  word to substitute; chunk i = in_data[6i+5:6i].
REQ-008 SHALL have port: sbox_in  output  6  chunk driven to the external 6-bit sbox (1-cycle registered lookup).
REQ-009 SHALL have port: sbox_out  input  6  registered sbox result, valid one edge after sbox_in.
REQ-010 SHALL have port: out_valid  output  1  substituted word valid.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts word.
REQ-012 SHALL have port: out_data  output  W  substituted word; field i = S(chunk i).
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FEED, DRAIN, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; input handshake = in_valid & in_ready at a posedge.
REQ-016 SHALL on input handshake latch in_data into an internal register, clear chunk index to 0, go to FEED; in_data ignored at all other times.
REQ-017 SHALL in FEED drive sbox_in combinationally from latched chunk[idx]; elsewhere sbox_in = 6'h00.
REQ-018 SHALL in FEED increment idx each edge; on edge with idx = NCHUNK-1 go to DRAIN.
REQ-019 SHALL capture sbox_out into out_data field (k) on the edge one cycle after chunk k was driven, for k = 0..NCHUNK-1 (captures on FEED edges idx>=1 and on the DRAIN edge).
REQ-020 SHALL leave DRAIN after exactly one edge to DONE.
REQ-021 SHALL assert out_valid only in DONE; out_valid first high NCHUNK+1 edges after input handshake edge (11 for default).
REQ-022 SHALL hold out_data and out_valid stable in DONE while out_ready=0.
REQ-023 SHALL on out_valid & out_ready edge go to IDLE; out_data retains last value until next capture.
REQ-024 SHALL not accept a new word in the same edge as the output handshake (minimum word period NCHUNK+3 edges).
REQ-025 SHALL ignore out_ready outside DONE and in_valid outside IDLE.

Reset
REQ-026 SHALL on rst=1 at a posedge: state IDLE, idx 0, out_valid 0, out_data 0, internal word 0, busy 0, in_ready 1 after the edge.
REQ-027 SHALL give rst priority over every handshake; reset mid-FEED/DRAIN/DONE discards the word with no out_valid pulse.
REQ-028 SHALL, with rst held high, keep sbox_in = 6'h00 and out_valid = 0.

Verification
REQ-029 SHALL check: in_data = 0 accepted, out_ready=1 -> out_valid high 11 edges later, every field of out_data = 6'h21, one-cycle pulse.
REQ-030 SHALL check: chunk i = i (i=0..9) -> fields 0..9 = 21,00,0e,2d,33,20,25,2c,1e,1c (hex); sbox_in sequence 0..9 on consecutive cycles.
REQ-031 SHALL check: all chunks 6'h3f, out_ready=0 for 5 cycles in DONE -> out_valid and out_data (all fields 6'h28) stable, in_ready=0 throughout, release on out_ready.
REQ-032 SHALL check: rst asserted at FEED idx 4 -> next cycle state IDLE, in_ready=1, out_valid=0, out_data=0; following word processed correctly.
REQ-033 SHALL check: in_valid held high continuously with changing in_data -> words accepted only in IDLE, each output matches the word sampled at its handshake, period 13 edges.
